// File: rtl/bsg_test_dram_channel_responder_pkg.sv
// Shared types and helpers for the fixed-latency DRAM channel responder.
// Request encoding matches the write_not_read bit of the channel interface.
package bsg_test_dram_channel_responder_pkg;

   typedef enum logic {
      REQ_READ  = 1'b0,
      REQ_WRITE = 1'b1
   } req_kind_e;

   // Byte-offset bits below the word index for a given data width.
   function automatic int byte_lsb(input int data_width);
      return $clog2(data_width / 8);
   endfunction

endpackage

// File: rtl/bsg_test_dram_channel_responder_if.sv
// Single-channel request/response bundle between a test master and the responder.
// Signal names keep the responder-side _i/_o orientation for both modports.
interface bsg_test_dram_channel_responder_if
   #(parameter int channel_addr_width_p = 16
   , parameter int data_width_p         = 32);

   logic                            v_i;
   logic                            write_not_read_i;
   logic [channel_addr_width_p-1:0] ch_addr_i;
   logic                            yumi_o;
   logic                            data_v_i;
   logic [data_width_p-1:0]         data_i;
   logic                            data_yumi_o;
   logic                            data_v_o;
   logic [data_width_p-1:0]         data_o;

   modport master (
      output v_i, write_not_read_i, ch_addr_i, data_v_i, data_i,
      input  yumi_o, data_yumi_o, data_v_o, data_o
   );

   modport slave (
      input  v_i, write_not_read_i, ch_addr_i, data_v_i, data_i,
      output yumi_o, data_yumi_o, data_v_o, data_o
   );

endinterface

// File: rtl/bsg_test_dram_channel_responder_fifo.sv
// Small circular-buffer FIFO with async-reset pointers; data_o is the head, 0-cycle read.
// No internal backpressure: caller must not push when full unless it pops in the same cycle.
module bsg_test_dram_channel_responder_fifo
   #(parameter int width_p = 8
   , parameter int els_p   = 2)
   (input  logic               clk_i
   , input  logic               reset_i
   , input  logic               v_i
   , input  logic [width_p-1:0] data_i
   , output logic               full_o
   , output logic               v_o
   , output logic [width_p-1:0] data_o
   , input  logic               yumi_i
   );

   localparam int ptr_w_lp = (els_p > 1) ? $clog2(els_p) : 1;
   localparam int cnt_w_lp = $clog2(els_p + 1);

   logic [ptr_w_lp-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
   logic [cnt_w_lp-1:0] count_q, count_d;
   logic [width_p-1:0]  slots_q [els_p];
   logic [width_p-1:0]  slots_d [els_p];

   function automatic logic [ptr_w_lp-1:0] bump(input logic [ptr_w_lp-1:0] p);
      return (p == ptr_w_lp'(els_p - 1)) ? '0 : p + 1'b1;
   endfunction

   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      slots_d = slots_q;
      if (v_i) begin
         slots_d[wptr_q] = data_i;
         wptr_d          = bump(wptr_q);
      end
      if (yumi_i) begin
         rptr_d = bump(rptr_q);
      end
      case ({v_i, yumi_i})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
      end
   end

   // Payload storage carries no reset; validity comes from count_q alone.
   always_ff @(posedge clk_i) begin
      slots_q <= slots_d;
   end

   assign full_o = (count_q == cnt_w_lp'(els_p));
   assign v_o    = (count_q != '0);
   assign data_o = slots_q[rptr_q];

endmodule

// File: rtl/bsg_test_dram_channel_responder.sv
// Fixed-latency DRAM channel model: writes update a word memory, reads return latency_p cycles later.
// Read accept stalls only when els_p reads are in flight and none pops; read data has no backpressure.
module bsg_test_dram_channel_responder
   import bsg_test_dram_channel_responder_pkg::*;
   #(parameter int channel_addr_width_p = 16
   , parameter int data_width_p         = 32
   , parameter int latency_p            = 4
   , parameter int els_p                = 4
   , parameter int mem_els_p            = 64)
   (input  logic clk_i
   , input  logic reset_i
   , bsg_test_dram_channel_responder_if.slave ch
   );

   localparam int lsb_lp    = byte_lsb(data_width_p);
   localparam int mem_aw_lp = $clog2(mem_els_p);
   localparam int tw_lp     = $clog2(latency_p + 1) + 1;

   typedef struct packed {
      logic [tw_lp-1:0]        due;
      logic [data_width_p-1:0] data;
   } entry_t;

   logic [data_width_p-1:0] mem_q [mem_els_p];
   logic [data_width_p-1:0] mem_d [mem_els_p];
   logic [tw_lp-1:0]        now_q, now_d;

   logic [channel_addr_width_p-1:0] addr;
   logic [mem_aw_lp-1:0]            word_idx;
   logic                            unused_addr;
   logic                            is_write, wr_acc, rd_acc;
   logic                            q_full, q_v, deq;
   entry_t                          head, push_e;

   // Upper address bits alias onto the same words.
   assign addr        = ch.ch_addr_i;
   assign word_idx    = addr[lsb_lp +: mem_aw_lp];
   assign unused_addr = ^addr;

   assign is_write = (req_kind_e'(ch.write_not_read_i) == REQ_WRITE);
   assign deq      = q_v & (now_q == head.due);
   assign wr_acc   = ~reset_i & ch.v_i &  is_write & ch.data_v_i;
   assign rd_acc   = ~reset_i & ch.v_i & ~is_write & (~q_full | deq);

   assign push_e.due  = now_q + tw_lp'(latency_p);
   assign push_e.data = mem_q[word_idx];

   always_comb begin
      now_d = now_q + 1'b1;
      mem_d = mem_q;
      if (wr_acc) begin
         mem_d[word_idx] = ch.data_i;
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         now_q <= '0;
      end else begin
         now_q <= now_d;
      end
   end

   always_ff @(posedge clk_i) begin
      mem_q <= mem_d;
   end

   bsg_test_dram_channel_responder_fifo #(
      .width_p ($bits(entry_t))
      ,.els_p  (els_p)
   ) inflight (
      .clk_i   (clk_i)
      ,.reset_i(reset_i)
      ,.v_i    (rd_acc)
      ,.data_i (push_e)
      ,.full_o (q_full)
      ,.v_o    (q_v)
      ,.data_o (head)
      ,.yumi_i (deq)
   );

   assign ch.yumi_o      = wr_acc | rd_acc;
   assign ch.data_yumi_o = wr_acc;
   assign ch.data_v_o    = deq & ~reset_i;
   assign ch.data_o      = head.data;

endmodule

// File: tb/tb_bsg_test_dram_channel_responder.sv
// Directed bench: default instance driven from a cycle table, els_p=2 instance and reset by hand.
module tb_bsg_test_dram_channel_responder;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   bsg_test_dram_channel_responder_if #(.channel_addr_width_p(16), .data_width_p(32)) ch_a ();
   bsg_test_dram_channel_responder_if #(.channel_addr_width_p(16), .data_width_p(32)) ch_b ();

   bsg_test_dram_channel_responder dut_a (
      .clk_i   (clk)
      ,.reset_i(rst)
      ,.ch     (ch_a)
   );

   bsg_test_dram_channel_responder #(.els_p(2)) dut_b (
      .clk_i   (clk)
      ,.reset_i(rst)
      ,.ch     (ch_b)
   );

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic        v;
      logic        w;
      logic [15:0] addr;
      logic        dv;
      logic [31:0] d;
      logic        e_yumi;
      logic        e_dyumi;
      logic        e_dv;
      logic [31:0] e_do;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual %h required %h", name, act, exp);
      end
   endtask

   task automatic add(input logic v, input logic w, input logic [15:0] addr, input logic dv,
                      input logic [31:0] d, input logic ey, input logic edy, input logic edv,
                      input logic [31:0] edo);
      vec_t r;
      r.v = v; r.w = w; r.addr = addr; r.dv = dv; r.d = d;
      r.e_yumi = ey; r.e_dyumi = edy; r.e_dv = edv; r.e_do = edo;
      vecs.push_back(r);
   endtask

   task automatic idle(input logic edv, input logic [31:0] edo);
      add(1'b0, 1'b0, 16'h0, 1'b0, 32'h0, 1'b0, 1'b0, edv, edo);
   endtask

   task automatic drive_a(input logic v, input logic w, input logic [15:0] addr,
                          input logic dv, input logic [31:0] d);
      ch_a.v_i = v; ch_a.write_not_read_i = w; ch_a.ch_addr_i = addr;
      ch_a.data_v_i = dv; ch_a.data_i = d;
   endtask

   task automatic drive_b(input logic v, input logic w, input logic [15:0] addr,
                          input logic dv, input logic [31:0] d);
      ch_b.v_i = v; ch_b.write_not_read_i = w; ch_b.ch_addr_i = addr;
      ch_b.data_v_i = dv; ch_b.data_i = d;
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic build_table;
      idle(0, 0);                                                   // c0
      add(1, 1, 16'h0010, 1, 32'hDEADBEEF, 1, 1, 0, 0);             // c1 write
      add(1, 0, 16'h0010, 1, 32'h0, 1, 0, 0, 0);                    // c2 read, data_v_i ignored
      idle(0, 0); idle(0, 0); idle(0, 0);                           // c3-c5
      idle(1, 32'hDEADBEEF);                                        // c6 return
      idle(0, 0);                                                   // c7
      for (int i = 0; i < 8; i++)                                   // c8-c15 pattern writes
         add(1, 1, 16'(i * 4), 1, 32'(i) * 32'h11111111, 1, 1, 0, 0);
      for (int i = 0; i < 8; i++)                                   // c16-c23 streaming reads
         add(1, 0, 16'(i * 4), 0, 32'h0, 1, 0, (i >= 4) ? 1'b1 : 1'b0,
             (i >= 4) ? 32'(i - 4) * 32'h11111111 : 32'h0);
      for (int i = 4; i < 8; i++)                                   // c24-c27 tail of stream
         idle(1, 32'(i) * 32'h11111111);
      idle(0, 0);                                                   // c28
      for (int i = 0; i < 3; i++)                                   // c29-c31 write without data
         add(1, 1, 16'h0020, 0, 32'h1, 0, 0, 0, 0);
      add(1, 1, 16'h0020, 1, 32'h1, 1, 1, 0, 0);                    // c32 data arrives
      add(0, 0, 16'h0000, 1, 32'hFFFF, 0, 0, 0, 0);                 // c33 stray data_v_i
      add(1, 0, 16'h0020, 0, 32'h0, 1, 0, 0, 0);                    // c34 snapshot read (1)
      add(1, 1, 16'h0020, 1, 32'h2, 1, 1, 0, 0);                    // c35 overwrite with 2
      add(1, 0, 16'h0020, 0, 32'h0, 1, 0, 0, 0);                    // c36 read (2)
      idle(0, 0);                                                   // c37
      idle(1, 32'h1);                                               // c38
      idle(0, 0);                                                   // c39
      idle(1, 32'h2);                                               // c40
      idle(0, 0);                                                   // c41
      add(1, 0, 16'h0120, 0, 32'h0, 1, 0, 0, 0);                    // c42 aliased read of word 8
      idle(0, 0); idle(0, 0); idle(0, 0);                           // c43-c45
      idle(1, 32'h2);                                               // c46
      idle(0, 0);                                                   // c47
   endtask

   initial begin
      logic ey, edv;
      logic [31:0] edo;
      int acc;

      rst = 1'b1;
      drive_a(1, 1, 16'h0004, 1, 32'h5);
      drive_b(0, 0, 16'h0, 0, 32'h0);
      build_table();
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_yumi", 32'(ch_a.yumi_o), 32'h0);
      check("rst_data_yumi", 32'(ch_a.data_yumi_o), 32'h0);
      check("rst_data_v", 32'(ch_a.data_v_o), 32'h0);
      tick();
      rst = 1'b0;

      foreach (vecs[i]) begin
         drive_a(vecs[i].v, vecs[i].w, vecs[i].addr, vecs[i].dv, vecs[i].d);
         @(negedge clk);
         check($sformatf("vec%0d yumi", i), 32'(ch_a.yumi_o), 32'(vecs[i].e_yumi));
         check($sformatf("vec%0d data_yumi", i), 32'(ch_a.data_yumi_o), 32'(vecs[i].e_dyumi));
         check($sformatf("vec%0d data_v", i), 32'(ch_a.data_v_o), 32'(vecs[i].e_dv));
         if (vecs[i].e_dv)
            check($sformatf("vec%0d data", i), ch_a.data_o, vecs[i].e_do);
         tick();
      end
      drive_a(0, 0, 16'h0, 0, 32'h0);

      // els_p=2: load four words, then present four reads continuously.
      for (int i = 0; i < 4; i++) begin
         drive_b(1, 1, 16'(i * 4), 1, 32'hA0 + 32'(i));
         @(negedge clk);
         check($sformatf("b_wr%0d yumi", i), 32'(ch_b.yumi_o), 32'h1);
         tick();
      end
      acc = 0;
      for (int t = 0; t < 12; t++) begin
         drive_b((acc < 4) ? 1'b1 : 1'b0, 0, 16'(acc * 4), 0, 32'h0);
         ey   = (t == 0 || t == 1 || t == 4 || t == 5);
         edv  = (t == 4 || t == 5 || t == 8 || t == 9);
         edo  = (t == 4) ? 32'hA0 : (t == 5) ? 32'hA1 : (t == 8) ? 32'hA2 : 32'hA3;
         @(negedge clk);
         check($sformatf("b_full t%0d yumi", t), 32'(ch_b.yumi_o), 32'(ey));
         check($sformatf("b_full t%0d data_v", t), 32'(ch_b.data_v_o), 32'(edv));
         if (edv) check($sformatf("b_full t%0d data", t), ch_b.data_o, edo);
         if (ey) acc++;
         tick();
      end

      // Write accepted while the read queue is full; read blocked until a pop frees a slot.
      for (int t = 0; t < 10; t++) begin
         logic edy;
         case (t)
            0:       drive_b(1, 0, 16'h0000, 0, 32'h0);
            1:       drive_b(1, 0, 16'h0004, 0, 32'h0);
            2:       drive_b(1, 1, 16'h0030, 1, 32'h55);
            3, 4:    drive_b(1, 0, 16'h0030, 0, 32'h0);
            default: drive_b(0, 0, 16'h0000, 0, 32'h0);
         endcase
         ey  = (t <= 2 || t == 4);
         edy = (t == 2);
         edv = (t == 4 || t == 5 || t == 8);
         edo = (t == 4) ? 32'hA0 : (t == 5) ? 32'hA1 : 32'h55;
         @(negedge clk);
         check($sformatf("b_wfull t%0d yumi", t), 32'(ch_b.yumi_o), 32'(ey));
         check($sformatf("b_wfull t%0d data_yumi", t), 32'(ch_b.data_yumi_o), 32'(edy));
         check($sformatf("b_wfull t%0d data_v", t), 32'(ch_b.data_v_o), 32'(edv));
         if (edv) check($sformatf("b_wfull t%0d data", t), ch_b.data_o, edo);
         tick();
      end

      // Three reads in flight, then reset lands in the cycle the first one is due.
      for (int i = 1; i <= 3; i++) begin
         drive_a(1, 0, 16'(i * 4), 0, 32'h0);
         tick();
      end
      drive_a(0, 0, 16'h0, 0, 32'h0);
      tick();
      check("pre_rst data_v", 32'(ch_a.data_v_o), 32'h1);
      check("pre_rst data", ch_a.data_o, 32'h11111111);
      #2;
      rst = 1'b1;
      drive_a(1, 0, 16'h0004, 0, 32'h0);
      #1;
      check("rst_async data_v", 32'(ch_a.data_v_o), 32'h0);
      check("rst_hold yumi", 32'(ch_a.yumi_o), 32'h0);
      tick();
      tick();
      rst = 1'b0;
      drive_a(0, 0, 16'h0, 0, 32'h0);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check($sformatf("post_rst%0d data_v", i), 32'(ch_a.data_v_o), 32'h0);
         tick();
      end
      drive_a(1, 0, 16'h0008, 0, 32'h0);
      @(negedge clk);
      check("retained yumi", 32'(ch_a.yumi_o), 32'h1);
      tick();
      drive_a(0, 0, 16'h0, 0, 32'h0);
      repeat (3) tick();
      @(negedge clk);
      check("retained data_v", 32'(ch_a.data_v_o), 32'h1);
      check("retained data", ch_a.data_o, 32'h22222222);
      tick();
      @(negedge clk);
      check("retained single", 32'(ch_a.data_v_o), 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
